// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - program counter and instruction fetch over a req/ack memory handshake
module inst_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          AW       = 10,
    parameter int          TIMEOUT  = 16
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic [1:0]    PC_SEL,
    input  logic          PC_MUX,
    input  logic [63:0]   K,
    input  logic [63:0]   A_bus,
    input  logic          step,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic [31:0]   Inst,
    output logic          Inst_valid,
    output logic [63:0]   PC,
    output logic          fetch_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [63:0]   r_pc;
    logic [63:0]   w_pc_nx;
    logic [31:0]   r_inst;
    logic [31:0]   w_inst_nx;
    logic          r_valid;
    logic          w_valid_nx;
    logic          r_req;
    logic          w_req_nx;
    logic          r_err;
    logic          w_err_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;

    logic [63:0]   w_pc_inc;
    logic [63:0]   w_pc_br;
    logic [63:0]   w_pc_jmp;
    logic          w_unused_bits;

    // K counts instruction words, so it is scaled to bytes before the add.
    assign w_pc_inc      = r_pc + 64'd4;
    assign w_pc_br       = r_pc + {K[61:0], 2'b00};
    assign w_pc_jmp      = {A_bus[63:2], 2'b00};
    assign w_unused_bits = ^{K[63:62], A_bus[1:0]};

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_inst  <= 32'h0;
            r_valid <= 1'b0;
            r_req   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_inst  <= w_inst_nx;
            r_valid <= w_valid_nx;
            r_req   <= w_req_nx;
            r_err   <= w_err_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_inst_nx  = r_inst;
        w_valid_nx = r_valid;
        w_req_nx   = r_req;
        w_err_nx   = r_err;
        w_cnt_nx   = r_cnt;

        unique case (r_state)
            S_FETCH: begin
                w_req_nx   = 1'b1;
                w_cnt_nx   = '0;
                w_state_nx = S_WAIT;
            end
            S_WAIT: begin
                // An ack arriving on the last allowed cycle still wins over the timeout.
                if (imem_ack && r_req) begin
                    w_inst_nx  = imem_rdata;
                    w_valid_nx = 1'b1;
                    w_req_nx   = 1'b0;
                    w_cnt_nx   = '0;
                    w_state_nx = S_EXEC;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_err_nx   = 1'b1;
                    w_req_nx   = 1'b0;
                    w_cnt_nx   = '0;
                    w_state_nx = S_FETCH;
                end else begin
                    w_cnt_nx   = r_cnt + CW'(1);
                end
            end
            S_EXEC: begin
                if (step) begin
                    unique case (PC_SEL)
                        2'b00: w_pc_nx = r_pc;
                        2'b01: w_pc_nx = w_pc_inc;
                        2'b10: w_pc_nx = PC_MUX ? w_pc_br : w_pc_inc;
                        2'b11: w_pc_nx = w_pc_jmp;
                        default: w_pc_nx = r_pc;
                    endcase
                    if (PC_SEL != 2'b00) begin
                        w_valid_nx = 1'b0;
                        w_state_nx = S_FETCH;
                    end
                end
            end
            default: begin
                w_req_nx   = 1'b0;
                w_state_nx = S_FETCH;
            end
        endcase
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_pc[AW+1:2];
    assign Inst       = r_inst;
    assign Inst_valid = r_valid;
    assign PC         = r_pc;
    assign fetch_err  = r_err;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

    logic        CLK;
    logic        Reset;
    logic [1:0]  PC_SEL;
    logic        PC_MUX;
    logic [63:0] K;
    logic [63:0] A_bus;
    logic        step;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Inst;
    logic        Inst_valid;
    logic [63:0] PC;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    inst_fetch_unit #(
        .RESET_PC (64'h0),
        .AW       (10),
        .TIMEOUT  (16)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .PC_SEL     (PC_SEL),
        .PC_MUX     (PC_MUX),
        .K          (K),
        .A_bus      (A_bus),
        .step       (step),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .Inst       (Inst),
        .Inst_valid (Inst_valid),
        .PC         (PC),
        .fetch_err  (fetch_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a request, optionally stalls, then returns one ack beat.
    task automatic serve(input logic [31:0] data, input int delay);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk("serve_req_seen", imem_req, 1);
        repeat (delay) @(negedge CLK);
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge CLK);
        imem_ack   = 1'b0;
    endtask

    task automatic do_step(input logic [1:0] sel, input logic mux, input logic [63:0] k, input logic [63:0] a);
        PC_SEL = sel;
        PC_MUX = mux;
        K      = k;
        A_bus  = a;
        step   = 1'b1;
        @(negedge CLK);
        step   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b0; PC_SEL = 2'b00; PC_MUX = 1'b0; K = '0; A_bus = '0;
        step = 1'b0; imem_ack = 1'b0; imem_rdata = '0;

        repeat (2) @(negedge CLK);
        chk("rst_pc", PC, 64'h0);
        chk("rst_valid", Inst_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_err", fetch_err, 0);
        chk("rst_inst", Inst, 0);

        Reset = 1'b1;
        @(negedge CLK);
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 0);
        @(negedge CLK);
        chk("first_not_valid", Inst_valid, 0);
        imem_ack = 1'b1; imem_rdata = 32'h91000421;
        @(negedge CLK);
        imem_ack = 1'b0;
        chk("first_valid", Inst_valid, 1);
        chk("first_inst", Inst, 32'h91000421);
        chk("first_pc", PC, 64'h0);
        chk("first_req_drop", imem_req, 0);

        do_step(2'b01, 1'b0, 64'h0, 64'h0);
        chk("inc_valid_drop", Inst_valid, 0);
        chk("inc_pc", PC, 64'h4);
        chk("inc_addr", imem_addr, 10'h1);
        serve(32'hA000_0004, 0);
        chk("inc_valid", Inst_valid, 1);
        chk("inc_inst", Inst, 32'hA000_0004);

        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge CLK);
        imem_ack = 1'b0;
        chk("stray_ack_inst", Inst, 32'hA000_0004);

        do_step(2'b01, 1'b0, 64'h0, 64'h0);
        chk("pc8", PC, 64'h8);
        serve(32'h1111_0008, 2);
        chk("pc8_inst", Inst, 32'h1111_0008);

        do_step(2'b00, 1'b1, 64'd99, 64'h40);
        chk("hold1_pc", PC, 64'h8);
        chk("hold1_valid", Inst_valid, 1);
        chk("hold1_req", imem_req, 0);
        chk("hold1_inst", Inst, 32'h1111_0008);
        do_step(2'b00, 1'b0, 64'h0, 64'h0);
        @(negedge CLK);
        chk("hold2_req", imem_req, 0);
        chk("hold2_pc", PC, 64'h8);
        do_step(2'b01, 1'b0, 64'h0, 64'h0);
        chk("hold_exit_pc", PC, 64'hC);
        chk("hold_exit_valid", Inst_valid, 0);
        serve(32'h2222_000C, 0);

        do_step(2'b01, 1'b0, 64'h0, 64'h0);
        chk("pc16", PC, 64'h10);
        serve(32'h3333_0010, 0);

        do_step(2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0);
        chk("br_back_pc", PC, 64'h8);
        serve(32'h4444_0008, 0);
        do_step(2'b10, 1'b1, 64'd5, 64'h0);
        chk("br_fwd_pc", PC, 64'h1C);
        serve(32'h5555_001C, 1);
        do_step(2'b10, 1'b0, 64'd5, 64'h0);
        chk("br_fallback_pc", PC, 64'h20);
        serve(32'h6666_0020, 0);

        do_step(2'b11, 1'b0, 64'h0, 64'h0000_0000_0000_0103);
        chk("jmp_pc", PC, 64'h100);
        chk("jmp_addr", imem_addr, 10'h040);
        serve(32'h7777_0100, 0);
        chk("jmp_inst", Inst, 32'h7777_0100);

        do_step(2'b11, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("jmp_top_pc", PC, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("jmp_top_addr", imem_addr, 10'h3FF);
        serve(32'h8888_FFFC, 0);
        do_step(2'b01, 1'b0, 64'h0, 64'h0);
        chk("wrap_pc", PC, 64'h0);
        chk("wrap_addr", imem_addr, 10'h0);

        @(negedge CLK);
        chk("ign_req", imem_req, 1);
        PC_SEL = 2'b11; A_bus = 64'h500; step = 1'b1;
        @(negedge CLK);
        step = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h9999_0000;
        @(negedge CLK);
        imem_ack = 1'b0;
        chk("ign_step_pc", PC, 64'h0);
        chk("ign_step_inst", Inst, 32'h9999_0000);
        chk("ign_step_valid", Inst_valid, 1);

        do_step(2'b01, 1'b0, 64'h0, 64'h0);
        chk("to_pc", PC, 64'h4);
        @(negedge CLK);
        chk("to_req_start", imem_req, 1);
        repeat (15) @(negedge CLK);
        chk("to_req_last", imem_req, 1);
        chk("to_err_before", fetch_err, 0);
        @(negedge CLK);
        chk("to_req_gap", imem_req, 0);
        chk("to_err_set", fetch_err, 1);
        chk("to_valid", Inst_valid, 0);
        @(negedge CLK);
        chk("to_retry_req", imem_req, 1);
        chk("to_retry_addr", imem_addr, 10'h1);
        chk("to_err_sticky", fetch_err, 1);

        @(negedge CLK);
        Reset = 1'b0;
        #1;
        chk("mid_rst_req", imem_req, 0);
        chk("mid_rst_err", fetch_err, 0);
        chk("mid_rst_pc", PC, 64'h0);
        chk("mid_rst_valid", Inst_valid, 0);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        imem_ack = 1'b0;
        chk("late_ack_valid", Inst_valid, 0);
        chk("late_ack_req", imem_req, 1);
        @(negedge CLK);
        chk("late_ack_valid2", Inst_valid, 0);
        serve(32'hC0DE_0000, 0);
        chk("recover_valid", Inst_valid, 1);
        chk("recover_inst", Inst, 32'hC0DE_0000);
        chk("recover_pc", PC, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
